// File: rtl/alu_rr_sched_if.sv
// alu_rr_sched_if: request/response bundle between the client engines and the
// shared-ALU scheduler.
// Optional feature macro: ALU_RR_ZERO_FLAG_EN adds the rsp_zero response flag.
// The master modport is the client side; the slave modport is the scheduler.
interface alu_rr_sched_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [3*NREQ-1:0]      req_op;
  logic [DATA_W*NREQ-1:0] req_a;
  logic [DATA_W*NREQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [DATA_W-1:0]      rsp_data;
`ifdef ALU_RR_ZERO_FLAG_EN
  logic                   rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
`endif
endinterface

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one 8-bit ALU between NREQ
// requesters. One operation is in flight at a time (IDLE -> EXEC -> RESP).
// Optional feature macro: ALU_RR_ZERO_FLAG_EN adds a registered rsp_zero flag
// that is high when the registered result is 0.

package aluvol2_pkg;
  localparam int N = 8;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_INV = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  // All arithmetic wraps modulo 2^N; carries and borrows are dropped.
  function automatic logic [N-1:0] alu_add(input logic [N-1:0] a, input logic [N-1:0] b);
    return a + b;
  endfunction

  function automatic logic [N-1:0] alu_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    return a - b;
  endfunction

  function automatic logic [N-1:0] alu_inc(input logic [N-1:0] a);
    return a + ONE;
  endfunction

  function automatic logic [N-1:0] alu_dec(input logic [N-1:0] a);
    return a - ONE;
  endfunction

  function automatic logic [N-1:0] alu_exec(input logic [2:0] op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      OP_ADD:  r = alu_add(a, b);
      OP_SUB:  r = alu_sub(a, b);
      OP_INC:  r = alu_inc(a);
      OP_DEC:  r = alu_dec(a);
      OP_INV:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = {N{1'b0}};
    endcase
    return r;
  endfunction
endpackage

module alu_rr_sched #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_rr_sched_if.slave bus
);
  import aluvol2_pkg::*;

  generate
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("alu_rr_sched: NREQ must be in 2..4");
    end
    if (DATA_W != aluvol2_pkg::N) begin : g_bad_width
      $error("alu_rr_sched: DATA_W must equal aluvol2_pkg::N");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [1:0]        last_grant_r;
  logic [1:0]        grant_s;
  logic              grant_found_s;
  logic [NREQ-1:0]   req_ready_s;

  logic [2:0]        op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [1:0]        id_r;

  logic [DATA_W-1:0] alu_res_s;
  logic              rsp_valid_r;
  logic [1:0]        rsp_id_r;
  logic [DATA_W-1:0] rsp_data_r;
`ifdef ALU_RR_ZERO_FLAG_EN
  logic              rsp_zero_r;
`endif

  // Round-robin pick: scan from last_grant+1 (mod NREQ), first valid wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = last_grant_r;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found_s && bus.req_valid[i] &&
            (((int'(last_grant_r) + k) % NREQ) == i)) begin
          grant_found_s = 1'b1;
          grant_s       = 2'(i);
        end else begin
          grant_found_s = grant_found_s;
        end
      end
    end
  end

  // FSM state register; async reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: grant in IDLE, one EXEC cycle, hold in RESP until accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: ready is one-hot to the winner, only while IDLE.
  always_comb begin
    req_ready_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_r == IDLE) && grant_found_s && (grant_s == 2'(i))) begin
        req_ready_s[i] = 1'b1;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  assign alu_res_s = alu_exec(op_r, a_r, b_r);

  // Datapath: capture the winner's payload, register the result, track grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= 3'd0;
      a_r          <= '0;
      b_r          <= '0;
      id_r         <= 2'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 2'd0;
      rsp_data_r   <= '0;
      last_grant_r <= 2'(NREQ - 1);
`ifdef ALU_RR_ZERO_FLAG_EN
      rsp_zero_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            op_r <= bus.req_op[3*grant_s +: 3];
            a_r  <= bus.req_a[DATA_W*grant_s +: DATA_W];
            b_r  <= bus.req_b[DATA_W*grant_s +: DATA_W];
            id_r <= grant_s;
          end
        end
        EXEC: begin
          rsp_data_r  <= alu_res_s;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
`ifdef ALU_RR_ZERO_FLAG_EN
          rsp_zero_r  <= (alu_res_s == '0);
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            last_grant_r <= id_r;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_data_r;
`ifdef ALU_RR_ZERO_FLAG_EN
  assign bus.rsp_zero  = rsp_zero_r;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched (NREQ=4). Stimulus pushes expected
// responses into a queue; a monitor pops and compares on each response handshake.
module tb_alu_rr_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic [9:0] exp_q[$];

  alu_rr_sched_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();

  alu_rr_sched #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {bus.rsp_id, bus.rsp_data}, 32'hDEAD);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", bus.rsp_id, e[9:8]);
        chk("rsp_data", bus.rsp_data, e[7:0]);
`ifdef ALU_RR_ZERO_FLAG_EN
        chk("rsp_zero", bus.rsp_zero, (e[7:0] == 8'h00));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[i]     = 1'b1;
    bus.req_op[3*i +: 3] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 4'd0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.req_ready != 4'd0) begin
        g = bus.req_ready;
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'd0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] e, input bit push);
    logic [3:0] g;
    @(posedge clk); #1;
    set_req(i, op, a, b);
    wait_grant(g);
    chk("grant_single", g, onehot(i));
    if (push) exp_q.push_back({2'(i), e});
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  // Two requesters raised together; i0 must win first, then i1.
  task automatic dual(input int i0, input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] e0,
                      input int i1, input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] e1);
    logic [3:0] g;
    @(posedge clk); #1;
    set_req(i0, op0, a0, b0);
    set_req(i1, op1, a1, b1);
    wait_grant(g);
    chk("grant_first", g, onehot(i0));
    exp_q.push_back({2'(i0), e0});
    @(posedge clk); #1;
    bus.req_valid[i0] = 1'b0;
    wait_grant(g);
    chk("grant_second", g, onehot(i1));
    exp_q.push_back({2'(i1), e1});
    @(posedge clk); #1;
    bus.req_valid[i1] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid) break;
    end
    chk("drain", {31'd0, (exp_q.size() == 0 && !bus.rsp_valid)}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    int prev_cyc;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 4'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 2'd0);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);

    // First transaction and its latency: add 0x12+0x34
    issue(0, 3'd0, 8'h12, 8'h34, 8'h46, 1'b1);
    @(negedge clk);
    chk("lat_exec_not_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("lat_resp_valid", bus.rsp_valid, 1'b1);
    drain();

    // Alternation from reset with both requesters holding inc requests
    do_reset();
    @(posedge clk); #1;
    set_req(0, 3'd2, 8'h10, 8'h00);
    set_req(1, 3'd2, 8'h20, 8'h00);
    prev_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      wait_grant(g);
      chk("alt_grant", g, onehot(n % 2));
      if (n > 0) chk("alt_interval", cyc - prev_cyc, 32'd3);
      prev_cyc = cyc;
      exp_q.push_back({2'(n % 2), ((n % 2) == 0) ? 8'h11 : 8'h21});
      @(posedge clk);
    end
    #1;
    bus.req_valid = '0;
    drain();

    // Wrap-around arithmetic
    issue(0, 3'd2, 8'hFF, 8'h00, 8'h00, 1'b1);
    issue(1, 3'd3, 8'h00, 8'h00, 8'hFF, 1'b1);
    issue(2, 3'd1, 8'h05, 8'h07, 8'hFE, 1'b1);
    issue(3, 3'd0, 8'h80, 8'h80, 8'h00, 1'b1);
    drain();

    // Backpressure: response held 5 cycles while requester 0 waits
    bus.rsp_ready = 1'b0;
    issue(1, 3'd7, 8'hF0, 8'h3C, 8'hCC, 1'b1);
    set_req(0, 3'd0, 8'h01, 8'h01);
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready},
          {1'b1, 2'd1, 8'hCC, 4'd0});
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_grant(g);
    chk("bp_next_grant", g, 4'b0001);
    exp_q.push_back({2'd0, 8'h02});
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    drain();

    // Asynchronous reset while a response is pending
    bus.rsp_ready = 1'b0;
    issue(1, 3'd5, 8'h0F, 8'hFF, 8'h0F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", bus.rsp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.rsp_valid, 1'b0);
    chk("async_rst_data", bus.rsp_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    dual(0, 3'd0, 8'h33, 8'h44, 8'h77, 1, 3'd1, 8'h50, 8'h10, 8'h40);
    drain();

    // Logic ops, requesters 3 and 1 from reset: 1 wins first
    do_reset();
    dual(1, 3'd5, 8'hF0, 8'h3C, 8'h30, 3, 3'd6, 8'hF0, 8'h3C, 8'hFC);
    issue(2, 3'd4, 8'h5A, 8'h00, 8'hA5, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one 8-bit ALU between NREQ requesters.
- The ALU executes the eight aluvol2_pkg operations (add, sub, inc, dec, inv, and, or, xor).
- Each requester issues operations over a valid/ready request channel.
- Results return on one shared response channel, tagged with the requester ID. The block sits between the client engines and the shared arithmetic resource.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4; anything else is an elaboration error.
- DATA_W, 8, operand/result width; must equal aluvol2_pkg::N; mismatch is an elaboration error.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accept; at most one bit high (one-hot or zero)
- req_op  in  3*NREQ  opcode, slice i = [3*i+:3]
- req_a  in  DATA_W*NREQ  operand A, slice i = [DATA_W*i+:DATA_W]
- req_b  in  DATA_W*NREQ  operand B, same slicing; ignored for inc/dec/inv
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  2  index of requester owning the response
- rsp_data  out  DATA_W  result

Behaviour:
- Opcode map: 0 add, 1 sub, 2 inc, 3 dec, 4 inv, 5 and, 6 or, 7 xor. Computed with the package functions.
- Arithmetic: all results are modulo 2^DATA_W and no carry or borrow is reported.
  - 0xFF inc = 0x00
  - 0x00 dec = 0xFF
  - 0x00 sub 0x01 = 0xFF
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, select the winner g. The search starts at last_grant+1 mod NREQ and picks the first valid requester found.
  - req_ready[g] is driven combinationally high in the same cycle; all other ready bits are low.
  - On that edge, capture op, A, B and g into internal registers, then go to EXEC.
  - With no valid requests, stay in IDLE and keep req_ready at zero.
- EXEC: compute the result from the captured registers, register it into rsp_data, set rsp_id=g and rsp_valid=1, then go to RESP. req_ready is zero.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready is high.
  - On the handshake edge: rsp_valid goes to 0, last_grant becomes g, and the FSM returns to IDLE.
  - req_ready is zero throughout RESP.
- Latency: request handshake at edge t gives rsp_valid high after edge t+1, i.e. visible in cycle t+1. Minimum issue interval is 3 cycles, achieved with rsp_ready tied high.
- Fairness: a requester that holds req_valid high is granted within NREQ arbitration rounds.
- Requester obligation: req_valid must stay high, with stable payload, until req_ready is seen. The block does not check this.
- Deasserting req_valid before grant is allowed; that requester is simply skipped.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0
  - state=IDLE
  - last_grant=NREQ-1, so requester 0 has first priority after reset
- Reset asserted mid-operation (EXEC or RESP) discards the in-flight operation immediately and asynchronously. No response is produced for it.
- rsp_ready high while rsp_valid is low has no effect.
- Unused rsp_id upper bits are 0.

Optional Feature:
- Macro: ALU_RR_ZERO_FLAG_EN
- Defined:
  - Adds output port rsp_zero, width 1, which is 1 when the registered result equals 0.
  - rsp_zero is registered alongside rsp_data, held with it in RESP, and reset to 0.
- Undefined: the port does not exist; all other behaviour is identical.

Test Plan:
- Reset release, req0 valid with op=0, A=0x12, B=0x34, rsp_ready=1:
  - req_ready=2'b01 in the first cycle
  - one cycle later rsp_valid=1, rsp_id=0, rsp_data=0x46
- Both requesters valid continuously, each with op=2 (inc) and A=0x10*(i+1), rsp_ready=1:
  - grants alternate 0,1,0,1
  - responses 0x11 (id 0), 0x21 (id 1), repeating
  - issue interval exactly 3 cycles
- Wrap cases: inc 0xFF → 0x00; dec 0x00 → 0xFF; sub 0x05−0x07 → 0xFE; add 0x80+0x80 → 0x00. With ALU_RR_ZERO_FLAG_EN, rsp_zero=1 exactly on the 0x00 results.
- Backpressure: hold rsp_ready=0 for 5 cycles during a response of xor 0xF0^0x3C:
  - rsp_data stays 0xCC, rsp_id stable and req_ready=0 across all 5 cycles
  - no second grant until the handshake completes
- Assert rst_n low during RESP:
  - rsp_valid drops to 0 without waiting for a clock edge
  - after release, requester 0 wins a simultaneous 0/1 request
- Logic ops with NREQ=4, requesters 3 and 1 valid, last_grant reset to 3:
  - requester 1 wins first, then requester 3
  - and 0xF0&0x3C → 0x30; or → 0xFC; inv 0x5A → 0xA5
